// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues req/ack fetches to instruction memory,
// buffers one instruction for IF/ID, and applies redirects, trap vectoring and flushes.
module fetch_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;

  logic            w_consume;
  logic            w_flush;
  logic            w_issue;
  logic [XLEN-1:0] w_target;

  always_comb begin
    w_consume = r_instr_valid & ~StallF;
    w_flush   = trap_valid | redirect_valid;
    w_issue   = ~w_flush & (~r_instr_valid | w_consume);
    w_target  = trap_valid ? TRAP_VEC : {redirect_pc[XLEN-1:2], 2'b00};
  end

  // Request is gated by reset so the bus is quiet while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    if (!reset) begin
      case (r_state)
        IDLE:    imem_req = w_issue;
        default: begin
          imem_req  = 1'b1;
          imem_addr = r_req_addr;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_req_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP;
      r_instr_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_flush) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
          end else if (w_issue && imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + XLEN'(4);
          end else if (w_issue) begin
            r_req_addr    <= r_pc;
            r_state       <= WAIT;
            r_instr_valid <= 1'b0;
          end else if (w_consume) begin
            r_instr_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (w_flush) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
            r_state       <= imem_ack ? IDLE : DRAIN;
          end else if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_req_addr;
            r_instr_valid <= 1'b1;
            r_pc          <= r_req_addr + XLEN'(4);
            r_state       <= IDLE;
          end
        end
        DRAIN: begin
          // Stale response is dropped; a further flush only retargets the PC.
          if (w_flush) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
          end
          if (imem_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCF         = r_pc;
    instr_valid = r_instr_valid;
    instr       = r_instr;
    instr_pc    = r_instr_pc;
    fetch_busy  = (r_state == WAIT) || (r_state == DRAIN);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: inputs change on the falling edge,
// outputs are checked 1 time unit later, away from the rising edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PCF           (PCF),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_busy    (fetch_busy)
  );

  // Memory returns a word derived from the address so each fetch is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; imem_ack = 1'b1;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_busy", 32'(fetch_busy), 32'd0);

    // Same-cycle ack, no stall: one fetch per cycle.
    step(); reset = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin step(); #1; end
      chk("s1_req", 32'(imem_req), 32'd1);
      chk("s1_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        chk("s1_valid", 32'(instr_valid), 32'd1);
        chk("s1_ipc", instr_pc, 32'(4 * (k - 1)));
        chk("s1_instr", instr, mem_word(32'(4 * (k - 1))));
      end
    end

    // Stall with 0x8 buffered: no request, buffer held.
    for (int k = 0; k < 4; k++) begin
      step(); StallF = 1'b1; #1;
      chk("st_req", 32'(imem_req), 32'd0);
      chk("st_ipc", instr_pc, 32'h8);
      chk("st_instr", instr, mem_word(32'h8));
      chk("st_pcf", PCF, 32'hC);
    end
    step(); StallF = 1'b0; #1;
    chk("st_rel_req", 32'(imem_req), 32'd1);
    chk("st_rel_addr", imem_addr, 32'hC);

    // Reset pulse, then 3-cycle ack latency.
    step(); reset = 1'b1; imem_ack = 1'b0; #1;
    chk("r2_pcf", PCF, 32'h0);
    step(); reset = 1'b0; #1;
    chk("l3_req0", 32'(imem_req), 32'd1);
    chk("l3_addr0", imem_addr, 32'h0);
    chk("l3_busy0", 32'(fetch_busy), 32'd0);
    for (int k = 1; k < 3; k++) begin
      step();
      if (k == 2) imem_ack = 1'b1;
      #1;
      chk("l3_req", 32'(imem_req), 32'd1);
      chk("l3_addr", imem_addr, 32'h0);
      chk("l3_busy", 32'(fetch_busy), 32'd1);
      chk("l3_valid", 32'(instr_valid), 32'd0);
    end
    step(); imem_ack = 1'b0; #1;
    chk("l3_vpulse", 32'(instr_valid), 32'd1);
    chk("l3_ipc", instr_pc, 32'h0);
    chk("l3_busy_idle", 32'(fetch_busy), 32'd0);
    chk("l3_addr_next", imem_addr, 32'h4);
    step(); #1;
    chk("l3_vdrop", 32'(instr_valid), 32'd0);
    chk("l3_busy2", 32'(fetch_busy), 32'd1);

    // Redirect to unaligned 0x43 while WAIT on 0x4: drain, discard, refetch 0x40.
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step(); redirect_valid = 1'b0; #1;
    chk("dr_pcf", PCF, 32'h40);
    chk("dr_req", 32'(imem_req), 32'd1);
    chk("dr_addr", imem_addr, 32'h4);
    chk("dr_busy", 32'(fetch_busy), 32'd1);
    step(); imem_ack = 1'b1; #1;
    chk("dr_ack_addr", imem_addr, 32'h4);
    step(); #1;
    chk("dr_discard", 32'(instr_valid), 32'd0);
    chk("dr_idle", 32'(fetch_busy), 32'd0);
    chk("dr_next_addr", imem_addr, 32'h40);
    step(); #1;
    chk("dr_new_valid", 32'(instr_valid), 32'd1);
    chk("dr_new_ipc", instr_pc, 32'h40);
    chk("dr_new_instr", instr, mem_word(32'h40));

    // Trap and redirect together in IDLE with a buffered instruction: trap wins.
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
    chk("tr_noreq", 32'(imem_req), 32'd0);
    step(); trap_valid = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0; #1;
    chk("tr_pcf", PCF, 32'h100);
    chk("tr_valid", 32'(instr_valid), 32'd0);
    chk("tr_addr", imem_addr, 32'h100);

    // Reset in the middle of WAIT.
    step(); #1;
    chk("rw_busy", 32'(fetch_busy), 32'd1);
    reset = 1'b1; #1;
    chk("rw_req", 32'(imem_req), 32'd0);
    chk("rw_pcf", PCF, 32'h0);
    chk("rw_busy_clr", 32'(fetch_busy), 32'd0);

    // PC wrap at the top of the address space.
    step(); reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("wr_noreq", 32'(imem_req), 32'd0);
    step(); redirect_valid = 1'b0; imem_ack = 1'b1; #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step(); #1;
    chk("wr_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_next_addr", imem_addr, 32'h0);
    chk("wr_pcf", PCF, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
